// File: rtl/riscv_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_if_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_DRAIN = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_if_fifo.sv
// Small synchronous FIFO with flush; head is always visible on head_o.
module riscv_if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/riscv_if.sv
// Instruction fetch: PC generation, req/gnt/rvalid memory port, instruction buffer to ID.
module riscv_if
    import riscv_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] kill_q, kill_d;
    logic [31:0] last_pc_q;

    if_entry_t   fifo_head;
    logic [CW-1:0] fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic [31:0] out_pc;
    logic [CW-1:0] out_count;
    logic        out_empty;
    logic        out_full;

    logic        handshake;
    logic        resp;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;

    assign resp    = imem_rvalid_i & ~out_empty;
    assign valid_o = ~rst & ~fifo_empty & ~br_taken_i;
    assign pop     = valid_o & ~stall_i;

    // A slot freed by this cycle's pop is lent to a new request, which is what
    // sustains one instruction per cycle with a two-entry buffer.
    assign credit_used = {1'b0, out_count} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign imem_req_o  = ~rst & (state_q == IF_FETCH) & ~br_taken_i & ~out_full
                       & (credit_used < (CW+1)'(FIFO_DEPTH));
    assign handshake   = imem_req_o & imem_gnt_i;
    assign push        = resp & (kill_q == '0) & ~br_taken_i & (~fifo_full | pop);
    assign imem_addr_o = fetch_pc_q;

    assign pc_o   = rst ? RESET_PC : (valid_o ? fifo_head.pc : last_pc_q);
    assign inst_o = valid_o ? fifo_head.inst : INST_NOP;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        fetch_pc_d = fetch_pc_q;
        if (handshake) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (resp && kill_q != '0) begin
            kill_d = kill_q - CW'(1);
        end
        if (br_taken_i) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = word_align(br_target_i);
            kill_d     = out_count + CW'(handshake) - CW'(resp);
            state_d    = (kill_d != '0) ? IF_DRAIN : IF_FETCH;
        end else if (state_q == IF_DRAIN && kill_d == '0) begin
            state_d = IF_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_FETCH;
            fetch_pc_q <= word_align(RESET_PC);
            kill_q     <= '0;
            last_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            if (valid_o) begin
                last_pc_q <= fifo_head.pc;
            end
        end
    end

    riscv_if_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_out_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (handshake),
        .push_data_i (fetch_pc_q),
        .pop_i       (resp),
        .flush_i     (1'b0),
        .head_o      (out_pc),
        .count_o     (out_count),
        .empty_o     (out_empty),
        .full_o      (out_full)
    );

    riscv_if_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({out_pc, imem_rdata_i}),
        .pop_i       (pop),
        .flush_i     (br_taken_i),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

endmodule

// File: tb/tb_riscv_if.sv
// Scoreboard bench for riscv_if: memory model with programmable latency, directed phases.
module tb_riscv_if;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    lat = 1;
    exp_t  sb_q[$];
    mreq_t pend_q[$];
    mreq_t mreq;
    exp_t  exp_e;

    riscv_if #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .stall_i       (stall),
        .pc_o          (pc),
        .inst_o        (inst),
        .valid_o       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a << 5) + 32'h13;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{start + 32'(4 * i), word_of(start + 32'(4 * i))});
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected instructions never delivered, required 0", name, sb_q.size());
        end
    endtask

    // Memory: accepts every req&gnt, answers in order after lat cycles; reset with the core.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            mreq        = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mreq.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else if (imem_req && imem_gnt) begin
            pend_q.push_back('{imem_addr, cyc + lat});
        end
    end

    // Monitor: every consumed instruction must be the next scoreboard entry.
    always @(negedge clk) begin
        if (valid && !stall) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_txn: got pc=%08h inst=%08h expected none", pc, inst);
            end else begin
                exp_e = sb_q.pop_front();
                if (pc !== exp_e.pc || inst !== exp_e.inst) begin
                    failures++;
                    $display("FAIL txn: got pc=%08h inst=%08h expected pc=%08h inst=%08h",
                             pc, inst, exp_e.pc, exp_e.inst);
                end else begin
                    $display("txn pc=%08h inst=%08h", pc, inst);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        br_taken = 1'b0; br_target = '0; stall = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);

        // 1: streaming, first valid on 3rd cycle after rst low
        push_exp(32'h0, 8);
        rst = 1'b0;
        tick(); chk("p1_c1_valid", 32'(valid), 32'd0);
        tick(); chk("p1_c2_pc", pc, 32'h0); chk("p1_c2_valid", 32'(valid), 32'd1);
        tick(); chk("p1_c3_pc", pc, 32'h4);
        tick(); chk("p1_c4_pc", pc, 32'h8);
        wait_drain("p1_drain");
        stall = 1'b1;

        // 2: stall 5 cycles with full buffer
        repeat (5) tick();
        chk("p2_req", 32'(imem_req), 32'd0);
        chk("p2_pc_hold", pc, 32'h20);
        chk("p2_inst_hold", inst, word_of(32'h20));
        chk("p2_addr", imem_addr, 32'h28);
        push_exp(32'h20, 8);
        stall = 1'b0;
        wait_drain("p2_drain");
        stall = 1'b1;
        tick(); tick();

        // 3: redirect with two outstanding requests
        lat = 4;
        br_taken = 1'b1; br_target = 32'h200;
        #1 chk("p3_br1_valid", 32'(valid), 32'd0);
        tick(); br_taken = 1'b0;
        tick(); tick();
        br_taken = 1'b1; br_target = 32'h103; stall = 1'b0;
        #1 chk("p3_br2_valid", 32'(valid), 32'd0);
        push_exp(32'h100, 8);
        tick(); br_taken = 1'b0; lat = 1;
        chk("p3_drain_req", 32'(imem_req), 32'd0);
        chk("p3_addr", imem_addr, 32'h100);
        wait_drain("p3_drain");
        stall = 1'b1;
        tick(); tick();

        // 4: grant withheld for 4 cycles
        imem_gnt = 1'b0; br_taken = 1'b1; br_target = 32'h300; stall = 1'b0;
        tick(); br_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("p4_addr_stable", imem_addr, 32'h300);
            chk("p4_valid", 32'(valid), 32'd0);
            tick();
        end
        push_exp(32'h300, 8);
        imem_gnt = 1'b1;
        wait_drain("p4_drain");
        stall = 1'b1;
        tick(); tick();

        // 5: fetch address wraps past 0xFFFF_FFFC
        br_taken = 1'b1; br_target = 32'hFFFF_FFF0;
        tick(); br_taken = 1'b0;
        push_exp(32'hFFFF_FFF0, 8);
        stall = 1'b0;
        wait_drain("p5_drain");
        stall = 1'b1;

        // 6: reset with a full buffer
        repeat (4) tick();
        chk("p6_pre_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("p6_valid", 32'(valid), 32'd0);
        chk("p6_inst", inst, 32'h0000_0013);
        chk("p6_addr", imem_addr, 32'h0);
        chk("p6_req", 32'(imem_req), 32'd0);
        chk("p6_pc", pc, 32'h0);
        rst = 1'b0;
        push_exp(32'h0, 4);
        stall = 1'b0;
        wait_drain("p6_drain");
        stall = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
